program_counter: RTL
====================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter: WIDTH, default 16, counter width in bits (legal range 2..32).
REQ-002 Parameter: RESET_VAL, default 0, value loaded into q by reset.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous reset, active-high.
REQ-005 Port: st  input  1  store; when high, load x into q.
REQ-006 Port: x  input  WIDTH  load value.
REQ-007 Port: stall  input  1  when high, hold q (no increment).
REQ-008 Port: halt_req  input  1  request entry to HALT (present only with PC_HALT_EN).
REQ-009 Port: resume  input  1  request return to RUN (present only with PC_HALT_EN).
REQ-010 Port: q  output  WIDTH  current count, registered.
REQ-011 Port: wrap  output  1  one-cycle pulse, registered; marks an increment from all-ones to zero.
REQ-012 Port: halted  output  1  high while the FSM is in HALT; constant 0 without PC_HALT_EN.

Function
REQ-013 Per-edge priority SHALL be: rst > st > (halted or stall) hold > increment.
REQ-014 st=1 SHALL set q<=x at the next edge, in every FSM state and regardless of stall; wrap<=0.
REQ-015 Increment SHALL be q<=q+1 modulo 2^WIDTH; the carry is discarded.
REQ-016 wrap SHALL be 1 exactly in the cycle after an increment from 2^WIDTH-1 to 0, and 0 otherwise; a load of 0 by st SHALL NOT assert wrap.
REQ-017 Hold SHALL keep q unchanged and drive wrap<=0.
REQ-018 The FSM SHALL have two states: RUN and HALT.
REQ-019 RUN->HALT SHALL occur when halt_req=1; the increment in that same cycle is suppressed.
REQ-020 HALT->RUN SHALL occur when resume=1 and halt_req=0; incrementing resumes in the following cycle.
REQ-021 When halt_req=1 and resume=1 in the same cycle, halt_req SHALL win: the FSM stays in or enters HALT.
REQ-022 Latency: every input SHALL take effect on q, wrap and halted at the next rising edge, with no combinational path from input to output.

Reset
REQ-023 rst=1 at an edge SHALL set q=RESET_VAL, wrap=0, halted=0 and FSM=RUN, overriding st, stall and halt inputs.
REQ-024 Reset asserted during HALT or during a wrap cycle SHALL produce the same result as REQ-023.

Configuration
REQ-025 Macro PC_HALT_EN: when defined, halt_req, resume and the RUN/HALT FSM SHALL be compiled in.
REQ-026 Without PC_HALT_EN, the halt_req and resume ports SHALL be absent, halted SHALL be tied to 0, and behaviour SHALL equal permanent RUN.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef (RUN, HALT) and the default WIDTH constant.
REQ-028 One sub-module, pc_incrementer, SHALL be used: combinational WIDTH-bit +1 producing the sum and carry-out; the carry-out feeds wrap.

Verification
REQ-029 Scenario: rst=1 with RESET_VAL=0x0005 -> q=0x0005, wrap=0, halted=0; then 3 free-running cycles -> q=0x0008.
REQ-030 Scenario: st=1, x=0xFFFE, then 2 increments -> q=0xFFFF then 0x0000; wrap=1 only in the cycle q=0x0000.
REQ-031 Scenario: stall=1 for 4 cycles at q=0x0010 -> q stays 0x0010; st=1, x=0x1234 during stall -> q=0x1234 next cycle.
REQ-032 Scenario (PC_HALT_EN): halt_req=1 at q=0x0020 -> halted=1, q=0x0020 held; halt_req=1 and resume=1 together -> stays HALT; resume alone -> RUN, next cycle q=0x0021.
REQ-033 Scenario: rst=1 while halted with st=1, x=0xAAAA -> q=RESET_VAL, halted=0.
REQ-034 Scenario (no PC_HALT_EN build): halted=0 always; free run from 0 for 2^WIDTH cycles -> exactly one wrap pulse.

Source files
------------

// File: rtl/program_counter_pkg.sv
// Shared types and constants for the program counter.
// Holds the RUN/HALT state encoding and the default counter width.
package program_counter_pkg;

    localparam int PC_WIDTH_DEFAULT = 16;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_incrementer.sv
// Combinational WIDTH-bit +1 adder for the program counter.
// The carry-out marks the all-ones to zero rollover.
module pc_incrementer #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // Extend by one bit so the rollover shows up as the top bit.
    assign {carry, sum} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/program_counter.sv
// Loadable, stallable program counter with a registered wrap pulse.
// Define PC_HALT_EN to add halt_req/resume and the RUN/HALT FSM.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic [WIDTH-1:0] x,
    input  logic             stall,
`ifdef PC_HALT_EN
    input  logic             halt_req,
    input  logic             resume,
`endif
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             halted
);

    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             hold;

    pc_incrementer #(
        .WIDTH (WIDTH)
    ) u_inc (
        .a     (q),
        .sum   (sum),
        .carry (carry)
    );

`ifdef PC_HALT_EN
    pc_state_t state_q;
    pc_state_t state_d;

    // State register; reset always returns to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: halt_req wins over resume in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (halt_req) state_d = HALT;
            end
            HALT: begin
                if (resume && !halt_req) state_d = RUN;
            end
        endcase
    end

    assign halted = (state_q == HALT);
    // The increment is also suppressed in the cycle halt is requested.
    assign hold   = stall || halted || halt_req;
`else
    assign halted = 1'b0;
    assign hold   = stall;
`endif

    // Counter and wrap pulse: rst > st > hold > increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RESET_VAL;
            wrap <= 1'b0;
        end else if (st) begin
            q    <= x;
            wrap <= 1'b0;
        end else if (hold) begin
            wrap <= 1'b0;
        end else begin
            q    <= sum;
            wrap <= carry;
        end
    end

endmodule
